aperture_scheduler: RTL and testbench

Sequencer sitting between the sixteen memory-aperture descriptors and the DDR3 SDRAM port. It resolves which aperture claims each A8 bus access and translates the A8 address into a 27-bit SDRAM byte address. It runs a single-outstanding request/acknowledge transaction against the SDRAM controller and returns read data to the A8 bus logic. It also muxes descriptor config-space readback into one result.

---
 rtl/aperture_scheduler.sv | 151 +++++++++++++++
 tb/tb_aperture_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aperture_scheduler.sv
// Aperture resolver and single-outstanding SDRAM request sequencer for A8 bus accesses.
// Also registers a priority mux of descriptor config readback.
module aperture_scheduler #(
  parameter int unsigned NUM_AP    = 16,
  parameter int unsigned RAMH      = 27,
  parameter logic [7:0]  CFG_SPACE = 8'hD7,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                   clk,
  input  logic                   a8_rst_n,
  input  logic                   a8_rw,
  input  logic [15:0]            a8_addr,
  input  logic [7:0]             a8_data,
  input  logic                   aValid,
  input  logic                   wValid,
  input  logic [NUM_AP-1:0]      apInRange,
  input  logic [NUM_AP*8-1:0]    apLoPage,
  input  logic [NUM_AP*RAMH-1:0] apBaseAddr,
  input  logic [NUM_AP*8-1:0]    apCfg,
  input  logic [NUM_AP-1:0]      apCfgValid,
  output logic                   memReq,
  output logic                   memWrite,
  output logic [RAMH-1:0]        memAddr,
  output logic [7:0]             memWData,
  input  logic                   memAck,
  input  logic [7:0]             memRData,
  output logic [7:0]             rdData,
  output logic                   rdValid,
  output logic [7:0]             cfgData,
  output logic                   cfgValid,
  output logic                   busy,
  output logic                   timeout,
  output logic                   overrun
);

  typedef enum logic [1:0] {StIdle, StWdata, StReq} state_e;

  state_e          r_state;
  logic [7:0]      r_cnt;
  logic            r_rw;

  logic            w_hit;
  logic            w_expired;
  logic [7:0]      w_lo;
  logic [RAMH-1:0] w_base;
  logic [15:0]     w_off;
  logic [RAMH-1:0] w_addr;
  logic [7:0]      w_cfg;

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    w_lo   = '0;
    w_base = '0;
    w_cfg  = '0;
    for (int i = NUM_AP - 1; i >= 0; i--) begin
      if (apInRange[i]) begin
        w_lo   = apLoPage[i*8 +: 8];
        w_base = apBaseAddr[i*RAMH +: RAMH];
      end
      if (apCfgValid[i]) begin
        w_cfg = apCfg[i*8 +: 8];
      end
    end
  end

  assign w_hit     = aValid && (|apInRange) && (a8_addr[15:8] != CFG_SPACE);
  assign w_off     = {a8_addr[15:8] - w_lo, a8_addr[7:0]};
  assign w_addr    = w_base + RAMH'(w_off);
  assign w_expired = (r_cnt == 8'(TIMEOUT - 1));
  assign busy      = (r_state != StIdle);

  always_ff @(posedge clk or negedge a8_rst_n) begin
    if (!a8_rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_rw     <= 1'b0;
      memReq   <= 1'b0;
      memWrite <= 1'b0;
      memAddr  <= '0;
      memWData <= '0;
      rdData   <= 8'hFF;
      rdValid  <= 1'b0;
      cfgData  <= 8'hFF;
      cfgValid <= 1'b0;
      timeout  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      rdValid  <= 1'b0;
      cfgValid <= |apCfgValid;
      if (|apCfgValid) begin
        cfgData <= w_cfg;
      end
      if (w_hit && r_state != StIdle) begin
        overrun <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (w_hit) begin
            memAddr <= w_addr;
            r_rw    <= a8_rw;
            r_cnt   <= '0;
            if (a8_rw) begin
              memWrite <= 1'b0;
              memReq   <= 1'b1;
              r_state  <= StReq;
            end else begin
              r_state  <= StWdata;
            end
          end
        end
        StWdata: begin
          if (wValid) begin
            memWData <= a8_data;
            memWrite <= 1'b1;
            memReq   <= 1'b1;
            r_cnt    <= '0;
            r_state  <= StReq;
          end else if (w_expired) begin
            timeout <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StReq: begin
          // Ack is checked first so it wins over a coincident expiry.
          if (memAck) begin
            memReq <= 1'b0;
            if (r_rw) begin
              rdData  <= memRData;
              rdValid <= 1'b1;
            end
            r_state <= StIdle;
          end else if (w_expired) begin
            memReq  <= 1'b0;
            timeout <= 1'b1;
            if (r_rw) begin
              rdData  <= 8'hFF;
              rdValid <= 1'b1;
            end
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aperture_scheduler.sv
// Directed bench for aperture_scheduler: a negedge monitor pops expected requests,
// read data and config readback from scoreboard queues.
module tb_aperture_scheduler;

  localparam int NA = 16;
  localparam int RH = 27;

  logic            clk = 1'b0;
  logic            a8_rst_n;
  logic            a8_rw;
  logic [15:0]     a8_addr;
  logic [7:0]      a8_data;
  logic            aValid;
  logic            wValid;
  logic [NA-1:0]   apInRange;
  logic [NA*8-1:0] apLoPage;
  logic [NA*RH-1:0] apBaseAddr;
  logic [NA*8-1:0] apCfg;
  logic [NA-1:0]   apCfgValid;
  logic            memReq;
  logic            memWrite;
  logic [RH-1:0]   memAddr;
  logic [7:0]      memWData;
  logic            memAck;
  logic [7:0]      memRData;
  logic [7:0]      rdData;
  logic            rdValid;
  logic [7:0]      cfgData;
  logic            cfgValid;
  logic            busy;
  logic            timeout;
  logic            overrun;

  aperture_scheduler dut (
    .clk        (clk),
    .a8_rst_n   (a8_rst_n),
    .a8_rw      (a8_rw),
    .a8_addr    (a8_addr),
    .a8_data    (a8_data),
    .aValid     (aValid),
    .wValid     (wValid),
    .apInRange  (apInRange),
    .apLoPage   (apLoPage),
    .apBaseAddr (apBaseAddr),
    .apCfg      (apCfg),
    .apCfgValid (apCfgValid),
    .memReq     (memReq),
    .memWrite   (memWrite),
    .memAddr    (memAddr),
    .memWData   (memWData),
    .memAck     (memAck),
    .memRData   (memRData),
    .rdData     (rdData),
    .rdValid    (rdValid),
    .cfgData    (cfgData),
    .cfgValid   (cfgValid),
    .busy       (busy),
    .timeout    (timeout),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RH-1:0] addr;
    logic          wr;
    logic [7:0]    wd;
  } req_t;

  req_t       req_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] cfg_q[$];
  int         total = 0;
  int         bad = 0;
  logic       prev_req = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input logic rw, input logic [15:0] addr, input logic [NA-1:0] rng);
    a8_rw     = rw;
    a8_addr   = addr;
    apInRange = rng;
    aValid    = 1'b1;
    tick();
    aValid    = 1'b0;
    a8_addr   = 16'hFFFF;
  endtask

  always @(negedge clk) begin
    if (memReq && !prev_req) begin
      if (req_q.size() == 0) begin
        check("unexpected_memReq", {31'd0, memReq}, 32'd0);
      end else begin
        req_t e;
        e = req_q.pop_front();
        check("memAddr", {5'd0, memAddr}, {5'd0, e.addr});
        check("memWrite", {31'd0, memWrite}, {31'd0, e.wr});
        if (e.wr) check("memWData", {24'd0, memWData}, {24'd0, e.wd});
      end
    end
    prev_req = memReq;
    if (rdValid) begin
      if (rd_q.size() == 0) check("unexpected_rdValid", {31'd0, rdValid}, 32'd0);
      else check("rdData", {24'd0, rdData}, {24'd0, rd_q.pop_front()});
    end
    if (cfgValid) begin
      if (cfg_q.size() == 0) check("unexpected_cfgValid", {31'd0, cfgValid}, 32'd0);
      else check("cfgData", {24'd0, cfgData}, {24'd0, cfg_q.pop_front()});
    end
  end

  initial begin
    int n;
    a8_rst_n   = 1'b0;
    a8_rw      = 1'b1;
    a8_addr    = '0;
    a8_data    = '0;
    aValid     = 1'b0;
    wValid     = 1'b0;
    apInRange  = '0;
    apLoPage   = '0;
    apBaseAddr = '0;
    apCfg      = '0;
    apCfgValid = '0;
    memAck     = 1'b0;
    memRData   = '0;
    apLoPage[3*8 +: 8]     = 8'h40;
    apBaseAddr[3*RH +: RH] = 27'h0012000;
    apLoPage[2*8 +: 8]     = 8'h80;
    apBaseAddr[2*RH +: RH] = 27'h7FFFF00;
    apLoPage[7*8 +: 8]     = 8'h81;
    apBaseAddr[7*RH +: RH] = 27'h0300000;
    tick();
    tick();
    check("rst_memReq", {31'd0, memReq}, 32'd0);
    check("rst_rdData", {24'd0, rdData}, 32'hFF);
    check("rst_cfgData", {24'd0, cfgData}, 32'hFF);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_memAddr", {5'd0, memAddr}, 32'd0);
    @(negedge clk);
    a8_rst_n = 1'b1;
    tick();

    // Read via aperture 3, ack two cycles after the hit
    req_q.push_back('{addr: 27'h0012123, wr: 1'b0, wd: 8'h00});
    rd_q.push_back(8'h5A);
    hit(1'b1, 16'h4123, 16'h0008);
    check("rd_busy", {31'd0, busy}, 32'd1);
    tick();
    memAck = 1'b1;
    memRData = 8'h5A;
    tick();
    memAck = 1'b0;
    check("rd_req_drop", {31'd0, memReq}, 32'd0);
    check("rd_busy_drop", {31'd0, busy}, 32'd0);

    // Priority 2 over 7 with address wrap, zero-wait ack
    req_q.push_back('{addr: 27'h0000080, wr: 1'b0, wd: 8'h00});
    rd_q.push_back(8'h77);
    hit(1'b1, 16'h8180, 16'h0084);
    memAck = 1'b1;
    memRData = 8'h77;
    tick();
    memAck = 1'b0;
    tick();

    // Stray wValid and memAck in IDLE must do nothing
    wValid = 1'b1;
    memAck = 1'b1;
    tick();
    wValid = 1'b0;
    memAck = 1'b0;
    tick();

    // Write: wValid three cycles after the hit
    req_q.push_back('{addr: 27'h0012200, wr: 1'b1, wd: 8'hC3});
    hit(1'b0, 16'h4200, 16'h0008);
    tick();
    check("wr_wait_noreq", {31'd0, memReq}, 32'd0);
    tick();
    a8_data = 8'hC3;
    wValid = 1'b1;
    tick();
    wValid = 1'b0;
    a8_data = 8'h00;
    tick();
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    check("wr_req_drop", {31'd0, memReq}, 32'd0);
    tick();

    // Config page is excluded; config mux picks the lowest valid bit
    hit(1'b1, 16'hD705, 16'h0001);
    check("cfgspace_busy", {31'd0, busy}, 32'd0);
    apCfg[4*8 +: 8] = 8'h11;
    apCfg[5*8 +: 8] = 8'h22;
    cfg_q.push_back(8'h11);
    apCfgValid = 16'h0030;
    tick();
    apCfgValid = '0;
    tick();
    check("pre_tmo_timeout", {31'd0, timeout}, 32'd0);
    check("pre_tmo_overrun", {31'd0, overrun}, 32'd0);

    // Timeout with an overlapping hit while in REQ
    req_q.push_back('{addr: 27'h0012123, wr: 1'b0, wd: 8'h00});
    rd_q.push_back(8'hFF);
    hit(1'b1, 16'h4123, 16'h0008);
    n = 0;
    while (memReq && n < 300) begin
      aValid = (n == 5);
      a8_addr = 16'h4123;
      n++;
      tick();
    end
    aValid = 1'b0;
    check("tmo_req_cycles", n, 32'd255);
    check("tmo_flag", {31'd0, timeout}, 32'd1);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    check("overrun_flag", {31'd0, overrun}, 32'd1);
    tick();
    tick();

    // Asynchronous reset mid-REQ; late ack ignored
    req_q.push_back('{addr: 27'h0012123, wr: 1'b0, wd: 8'h00});
    hit(1'b1, 16'h4123, 16'h0008);
    tick();
    #2;
    a8_rst_n = 1'b0;
    #1;
    check("arst_memReq", {31'd0, memReq}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_timeout", {31'd0, timeout}, 32'd0);
    check("arst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    a8_rst_n = 1'b1;
    tick();
    memAck = 1'b1;
    memRData = 8'h33;
    tick();
    memAck = 1'b0;
    tick();
    tick();
    check("post_rdData", {24'd0, rdData}, 32'hFF);
    check("left_req", req_q.size(), 32'd0);
    check("left_rd", rd_q.size(), 32'd0);
    check("left_cfg", cfg_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
